// File: rtl/mux_scanner.sv
// mux_scanner: clocked CHANNELS-to-1 word selector with manual select, continuous
// auto-scan and single triggered sweep, plus an active-low tri-state output strobe.
//
// Ports:
//   i_clk    rising-edge clock
//   i_rst    synchronous active-high reset
//   i_din    flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   i_sel    manual channel select
//   i_mode   00 manual, 01 continuous scan, 10 single sweep, 11 hold
//   i_start  one-cycle sweep trigger (mode 10, idle only)
//   i_oe_n   active-low output strobe (combinational)
//   o_out    registered selected word, high-Z while i_oe_n is high
//   o_ch     channel index of the word in the output register
//   o_valid  output register holds a live sample
//   o_busy   sweep in progress
//   o_wrap   one-cycle pulse after the scan pointer wraps to 0
//   o_done   one-cycle pulse after a sweep completes
module mux_scanner #(
  parameter int unsigned WIDTH    = 2,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SELW     = 2,
  parameter int unsigned DWELL    = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [CHANNELS*WIDTH-1:0]    i_din,
  input  logic [SELW-1:0]              i_sel,
  input  logic [1:0]                   i_mode,
  input  logic                         i_start,
  input  logic                         i_oe_n,
  output logic [WIDTH-1:0]             o_out,
  output logic [SELW-1:0]              o_ch,
  output logic                         o_valid,
  output logic                         o_busy,
  output logic                         o_wrap,
  output logic                         o_done
);

  typedef enum logic [2:0] {StManual, StScan, StIdle, StSweep, StHold} state_e;

  localparam logic [SELW-1:0] LastCh    = SELW'(CHANNELS - 1);
  localparam logic [7:0]      DwellLast = 8'(DWELL - 1);

  state_e            r_state, w_state, w_next;
  logic [WIDTH-1:0]  r_q;
  logic [SELW-1:0]   r_ch, r_ptr;
  logic [7:0]        r_dcnt;
  logic              r_valid, r_busy, r_wrap, r_done;
  logic              r_wrap_pend, r_done_pend;
  logic [WIDTH-1:0]  w_sel_word, w_ptr_word;
  logic              w_sel_ok, w_dwell_end, w_last;

  // Channel muxes for the manual select and the scan pointer.
  always_comb begin
    w_sel_word = '0;
    w_ptr_word = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (i_sel == SELW'(k)) w_sel_word = i_din[k*WIDTH +: WIDTH];
      if (r_ptr == SELW'(k)) w_ptr_word = i_din[k*WIDTH +: WIDTH];
    end
  end

  assign w_sel_ok    = 32'(i_sel) < CHANNELS;
  assign w_dwell_end = (r_dcnt == DwellLast);
  assign w_last      = (r_ptr == LastCh) && w_dwell_end;

  // w_state is the state acting on this edge: mode decides it every cycle, and
  // mode 10 only distinguishes a running sweep from idle via the stored state.
  always_comb begin
    w_state = r_state;
    case (i_mode)
      2'b00:   w_state = StManual;
      2'b01:   w_state = StScan;
      2'b11:   w_state = StHold;
      default: w_state = (r_state == StSweep) ? StSweep : StIdle;
    endcase
    w_next = w_state;
    if (w_state == StIdle && i_start) w_next = StSweep;
    if (w_state == StSweep && w_last) w_next = StIdle;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StManual;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q         <= '0;
      r_ch        <= '0;
      r_ptr       <= '0;
      r_dcnt      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_wrap      <= 1'b0;
      r_done      <= 1'b0;
      r_wrap_pend <= 1'b0;
      r_done_pend <= 1'b0;
    end else begin
      // Any mode change out of a sweep drops busy here, which is the abort.
      r_busy      <= (w_next == StSweep);
      r_wrap_pend <= 1'b0;
      r_done_pend <= 1'b0;
      // Pulses land the cycle after the last channel is loaded; hold suppresses them.
      r_wrap      <= r_wrap_pend && (w_state != StHold);
      r_done      <= r_done_pend && (w_state != StHold);
      case (w_state)
        StManual: begin
          r_ch <= i_sel;
          if (w_sel_ok) begin
            r_q     <= w_sel_word;
            r_valid <= 1'b1;
            r_ptr   <= i_sel;
            r_dcnt  <= '0;
          end else begin
            r_q     <= '0;
            r_valid <= 1'b0;
          end
        end
        StScan, StSweep: begin
          r_q     <= w_ptr_word;
          r_ch    <= r_ptr;
          r_valid <= 1'b1;
          if (w_dwell_end) begin
            r_dcnt <= '0;
            if (r_ptr == LastCh) begin
              r_ptr <= '0;
              if (w_state == StScan) r_wrap_pend <= 1'b1;
              else                   r_done_pend <= 1'b1;
            end else begin
              r_ptr <= r_ptr + SELW'(1);
            end
          end else begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end
        StIdle: begin
          r_valid <= 1'b0;
          if (i_start) begin
            r_ptr  <= '0;
            r_dcnt <= '0;
          end
        end
        default: ;  // StHold: everything frozen
      endcase
    end
  end

  assign o_out   = i_oe_n ? {WIDTH{1'bz}} : r_q;
  assign o_ch    = r_ch;
  assign o_valid = r_valid;
  assign o_busy  = r_busy;
  assign o_wrap  = r_wrap;
  assign o_done  = r_done;

endmodule

// File: tb/tb_mux_scanner.sv
// Bench for mux_scanner: instance A (4 channels, dwell 1) and instance B
// (3 channels, dwell 2), driven from a table of expected post-edge outputs.
module tb_mux_scanner;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: WIDTH=2, CHANNELS=4, SELW=2, DWELL=1
  logic       a_rst = 1'b1, a_start = 1'b0, a_oe_n = 1'b0;
  logic [7:0] a_din = 8'h1B;
  logic [1:0] a_sel = '0, a_mode = '0;
  logic [1:0] a_out, a_ch;
  logic       a_valid, a_busy, a_wrap, a_done;

  // Instance B: WIDTH=2, CHANNELS=3, SELW=2, DWELL=2
  logic       b_rst = 1'b1, b_start = 1'b0, b_oe_n = 1'b0;
  logic [5:0] b_din = 6'h1B;
  logic [1:0] b_sel = '0, b_mode = '0;
  logic [1:0] b_out, b_ch;
  logic       b_valid, b_busy, b_wrap, b_done;

  mux_scanner #(.WIDTH(2), .CHANNELS(4), .SELW(2), .DWELL(1)) u_a (
    .i_clk(clk), .i_rst(a_rst), .i_din(a_din), .i_sel(a_sel), .i_mode(a_mode),
    .i_start(a_start), .i_oe_n(a_oe_n), .o_out(a_out), .o_ch(a_ch),
    .o_valid(a_valid), .o_busy(a_busy), .o_wrap(a_wrap), .o_done(a_done)
  );

  mux_scanner #(.WIDTH(2), .CHANNELS(3), .SELW(2), .DWELL(2)) u_b (
    .i_clk(clk), .i_rst(b_rst), .i_din(b_din), .i_sel(b_sel), .i_mode(b_mode),
    .i_start(b_start), .i_oe_n(b_oe_n), .o_out(b_out), .o_ch(b_ch),
    .o_valid(b_valid), .o_busy(b_busy), .o_wrap(b_wrap), .o_done(b_done)
  );

  typedef struct {
    int         dut;
    logic       rst;
    logic [1:0] mode;
    logic [1:0] sel;
    logic       start;
    logic [7:0] din;
    logic [1:0] q;
    logic [1:0] ch;
    logic       v, b, w, d;
  } vec_t;

  vec_t vecs[$];
  vec_t sbq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic add(input int dut, input logic rst, input logic [1:0] mode,
                     input logic [1:0] sel, input logic start, input logic [7:0] din,
                     input logic [1:0] q, input logic [1:0] ch, input logic v,
                     input logic b, input logic w, input logic d);
    vec_t t;
    t.dut = dut; t.rst = rst; t.mode = mode; t.sel = sel; t.start = start; t.din = din;
    t.q = q; t.ch = ch; t.v = v; t.b = b; t.w = w; t.d = d;
    vecs.push_back(t);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    vec_t e;
    @(negedge clk);
    if (t.dut == 0) begin
      a_rst = t.rst; a_mode = t.mode; a_sel = t.sel; a_start = t.start; a_din = t.din;
    end else begin
      b_rst = t.rst; b_mode = t.mode; b_sel = t.sel; b_start = t.start; b_din = t.din[5:0];
    end
    sbq.push_back(t);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (e.dut == 0) begin
      check($sformatf("row%0d A out", idx),   {6'b0, a_out},  {6'b0, e.q});
      check($sformatf("row%0d A ch", idx),    {6'b0, a_ch},   {6'b0, e.ch});
      check($sformatf("row%0d A valid", idx), {7'b0, a_valid}, {7'b0, e.v});
      check($sformatf("row%0d A busy", idx),  {7'b0, a_busy},  {7'b0, e.b});
      check($sformatf("row%0d A wrap", idx),  {7'b0, a_wrap},  {7'b0, e.w});
      check($sformatf("row%0d A done", idx),  {7'b0, a_done},  {7'b0, e.d});
    end else begin
      check($sformatf("row%0d B out", idx),   {6'b0, b_out},  {6'b0, e.q});
      check($sformatf("row%0d B ch", idx),    {6'b0, b_ch},   {6'b0, e.ch});
      check($sformatf("row%0d B valid", idx), {7'b0, b_valid}, {7'b0, e.v});
      check($sformatf("row%0d B busy", idx),  {7'b0, b_busy},  {7'b0, e.b});
      check($sformatf("row%0d B wrap", idx),  {7'b0, b_wrap},  {7'b0, e.w});
      check($sformatf("row%0d B done", idx),  {7'b0, b_done},  {7'b0, e.d});
    end
  endtask

  initial begin
    // Reset and strobe: two reset cycles, then look at the output both ways.
    repeat (2) @(posedge clk);
    #1;
    check("rst out", {6'b0, a_out}, 8'h00);
    check("rst ch", {6'b0, a_ch}, 8'h00);
    check("rst valid", {7'b0, a_valid}, 8'h00);
    check("rst busy", {7'b0, a_busy}, 8'h00);
    a_oe_n = 1'b1;
    #1;
    n_tests++;
    if (a_out !== 2'bzz) begin
      n_fail++;
      $display("FAIL strobe hiz: got %b expected zz", a_out);
    end
    a_oe_n = 1'b0;

    // Instance A: din ch0..3 = 3,2,1,0
    //   dut rst mode   sel   st  din    q     ch    v  b  w  d
    add(0, 1, 2'b00, 2'd0, 0, 8'h1B, 2'd0, 2'd0, 0, 0, 0, 0);
    // manual
    add(0, 0, 2'b00, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(0, 0, 2'b00, 2'd1, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(0, 0, 2'b00, 2'd2, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b00, 2'd3, 0, 8'h1B, 2'd0, 2'd3, 1, 0, 0, 0);
    add(0, 0, 2'b00, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    // continuous scan from ptr 0: wrap the cycle after ch=3
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd0, 2'd3, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 1, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    // hold at ch=2 for 3 cycles, then resume (ptr already at 3)
    add(0, 0, 2'b11, 2'd0, 1, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b11, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b11, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd0, 2'd3, 1, 0, 0, 0);
    add(0, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 1, 0);
    // idle, then a sweep with a second start ignored mid-sweep
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 0, 0, 0, 0);
    add(0, 0, 2'b10, 2'd0, 1, 8'h1B, 2'd3, 2'd0, 0, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 1, 8'h1B, 2'd2, 2'd1, 1, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd0, 2'd3, 1, 0, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd0, 2'd3, 0, 0, 0, 1);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd0, 2'd3, 0, 0, 0, 0);
    // reset mid-sweep at ch=1: no done
    add(0, 0, 2'b10, 2'd0, 1, 8'h1B, 2'd0, 2'd3, 0, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 1, 0, 0);
    add(0, 1, 2'b10, 2'd0, 0, 8'h1B, 2'd0, 2'd0, 0, 0, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd0, 2'd0, 0, 0, 0, 0);
    // mode change mid-sweep aborts into manual on the same edge
    add(0, 0, 2'b10, 2'd0, 1, 8'h1B, 2'd0, 2'd0, 0, 1, 0, 0);
    add(0, 0, 2'b10, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 1, 0, 0);
    add(0, 0, 2'b00, 2'd2, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(0, 0, 2'b00, 2'd2, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);

    // Instance B: 3 channels, dwell 2, din ch0..2 = 3,2,1
    add(1, 1, 2'b00, 2'd0, 0, 8'h1B, 2'd0, 2'd0, 0, 0, 0, 0);
    add(1, 0, 2'b00, 2'd3, 0, 8'h1B, 2'd0, 2'd3, 0, 0, 0, 0);  // out-of-range select
    add(1, 0, 2'b00, 2'd1, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 2'b00, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 1, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd2, 2'd1, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd1, 2'd2, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h1B, 2'd3, 2'd0, 1, 0, 1, 0);
    // ch0 data changes mid-dwell and shows on the second dwell cycle
    add(1, 0, 2'b01, 2'd0, 0, 8'h18, 2'd0, 2'd0, 1, 0, 0, 0);
    add(1, 0, 2'b01, 2'd0, 0, 8'h18, 2'd2, 2'd1, 1, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
